router_modport: RTL and testbench

- Single-input, three-output (1x3) byte-serial packet router.
- Accepts packets on one 8-bit source port, checks parity, and steers each packet into one of three 16-deep output FIFOs selected by the header address.
- Each destination drains its FIFO with its own read enable.
- Sits between one write agent and three read agents.

---
 rtl/router_modport.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_router_modport.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_modport.sv
// -----------------------------------------------------------------------------
// router_modport -- 1x3 byte-serial packet router.
//
// One source streams packets of the form
//   header {len[7:2], addr[1:0]}, len payload bytes, one parity byte.
// The parity byte is the XOR of the header and all payload bytes.
// Each packet is steered into one of three output FIFOs by addr.
// addr = 3 is not a destination, and such a header is dropped.
// The router checks the parity.
// Each destination drains its FIFO with its own read enable.
//
// Handshake: the source advances to its next byte after any rising edge at
// which busy was low, and holds data_in/pkt_valid while busy is high.
//
// Ports
//   clk                   system clock, rising edge
//   resetn                synchronous active-low reset
//   data_in[7:0]          packet byte from the source
//   pkt_valid             high for header and payload, low on the parity byte
//   read_enb_0/1/2        destination pop requests
//   data_out_0/1/2[7:0]   popped byte, one cycle after the pop, held otherwise
//   vld_out_0/1/2         corresponding FIFO not empty
//   busy                  router cannot take data_in this cycle
//   err                   parity mismatch on the last packet
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// router_fifo -- one output FIFO with an idle-valid flush timer.
//
// Ports
//   clk, resetn      clock / synchronous active-low reset
//   wr_en, wr_data   push a 9-bit entry; bit 8 marks a header byte
//   rd_en            pop request; ignored while empty
//   data_out         byte of the last popped entry, held between pops
//   vld_out          FIFO not empty
//   full, empty      occupancy flags used by the router FSM
// -----------------------------------------------------------------------------
module router_fifo #(
    parameter int DEPTH           = 16,
    parameter int SOFT_RST_CYCLES = 30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       vld_out,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(SOFT_RST_CYCLES + 1);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] soft_cnt;
    logic [8:0]    rd_word;
    logic          do_wr;
    logic          do_rd;
    logic          soft_hit;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign vld_out = !empty;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_word = mem[rd_ptr];

    // The flush fires on the last of SOFT_RST_CYCLES consecutive idle-valid
    // cycles. Any pop request, or an empty FIFO, restarts the count.
    assign soft_hit = vld_out && !rd_en && (soft_cnt == SW'(SOFT_RST_CYCLES - 1));

    // NOTE: storage has no reset; emptiness is defined by count alone, so
    // stale entries are unreachable after reset or flush.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            soft_cnt <= '0;
            data_out <= '0;
        end else if (soft_hit) begin
            // The flush wins over a write issued in the same cycle.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            soft_cnt <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= rd_word[7:0];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (empty || rd_en) begin
                soft_cnt <= '0;
            end else begin
                soft_cnt <= soft_cnt + SW'(1);
            end
        end
    end

endmodule

module router_modport #(
    parameter int FIFO_DEPTH      = 16,
    parameter int SOFT_RST_CYCLES = 30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] data_in,
    input  logic       pkt_valid,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [7:0] data_out_0,
    output logic [7:0] data_out_1,
    output logic [7:0] data_out_2,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FIFO_FULL,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [7:0] header_q;     // accepted header, holds addr for the packet
    logic [7:0] byte_hold;    // byte taken while the FIFO could not store it
    logic [7:0] parity_acc;   // running XOR of header and stored payload
    logic [7:0] rx_parity;    // parity byte as received
    logic       err_q;

    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] fifo_vld;
    logic [2:0] wr_en_vec;
    logic [2:0] rd_en_vec;
    logic [7:0] fifo_dout [3];
    logic [8:0] fifo_wdata;
    logic       fifo_we;

    logic [1:0] addr_sel;
    logic [3:0] full_ext;
    logic [3:0] empty_ext;
    logic       tgt_full;
    logic       tgt_empty;
    logic       header_accept;

    // In DECODE the target comes from the header on the bus. In every other
    // state it comes from the latched header. addr 3 maps to a phantom port
    // that always reports full and never empty, so it never selects a load.
    assign addr_sel  = (state == DECODE) ? data_in[1:0] : header_q[1:0];
    assign full_ext  = {1'b1, fifo_full};
    assign empty_ext = {1'b0, fifo_empty};
    assign tgt_full  = full_ext[addr_sel];
    assign tgt_empty = empty_ext[addr_sel];

    assign header_accept = (state == DECODE) && pkt_valid && (data_in[1:0] != 2'b11);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= DECODE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output is assigned a default first, so no
    // path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            DECODE: begin
                if (header_accept) begin
                    next_state = tgt_empty ? LOAD_FIRST : WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                if (tgt_empty) begin
                    next_state = LOAD_FIRST;
                end
            end
            LOAD_FIRST: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else if (tgt_full) begin
                    next_state = FIFO_FULL;
                end
            end
            FIFO_FULL: begin
                if (!tgt_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: next_state = pkt_valid ? LOAD_DATA : LOAD_PARITY;
            LOAD_PARITY: begin
                // The parity byte may land on a full FIFO. Wait for room.
                if (!tgt_full) begin
                    next_state = CHECK_PARITY;
                end
            end
            CHECK_PARITY: next_state = DECODE;
            default:      next_state = DECODE;
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        fifo_we    = 1'b0;
        fifo_wdata = {1'b0, data_in};
        case (state)
            DECODE: begin
                busy = 1'b0;
            end
            LOAD_FIRST: begin
                fifo_we    = 1'b1;
                fifo_wdata = {1'b1, header_q};
            end
            LOAD_DATA: begin
                busy       = 1'b0;
                fifo_we    = pkt_valid && !tgt_full;
                fifo_wdata = {1'b0, data_in};
            end
            LOAD_AFTER_FULL: begin
                fifo_we    = 1'b1;
                fifo_wdata = {1'b0, byte_hold};
            end
            LOAD_PARITY: begin
                fifo_we    = !tgt_full;
                fifo_wdata = {1'b0, byte_hold};
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_en_vec = '0;
        for (int i = 0; i < 3; i++) begin
            wr_en_vec[i] = fifo_we && (header_q[1:0] == 2'(i));
        end
    end

    // ----------------------------------------------------------- datapath
    // busy is low in LOAD_DATA, so the source has already moved past the
    // byte on data_in when the FSM leaves LOAD_DATA. That byte is captured
    // into byte_hold so it survives a full FIFO or the parity phase.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            header_q   <= '0;
            byte_hold  <= '0;
            parity_acc <= '0;
            rx_parity  <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                DECODE: begin
                    if (header_accept) begin
                        header_q   <= data_in;
                        parity_acc <= data_in;
                        err_q      <= 1'b0;
                    end
                end
                LOAD_DATA: begin
                    if (pkt_valid && !tgt_full) begin
                        parity_acc <= parity_acc ^ data_in;
                    end
                    if (!pkt_valid || tgt_full) begin
                        byte_hold <= data_in;
                    end
                end
                LOAD_AFTER_FULL: begin
                    parity_acc <= parity_acc ^ byte_hold;
                    // The source is still holding the parity byte here.
                    if (!pkt_valid) begin
                        byte_hold <= data_in;
                    end
                end
                LOAD_PARITY: begin
                    if (!tgt_full) begin
                        rx_parity <= byte_hold;
                    end
                end
                CHECK_PARITY: begin
                    err_q <= (parity_acc != rx_parity);
                end
                default: ;
            endcase
        end
    end

    assign err = err_q;

    // --------------------------------------------------------- output side
    assign rd_en_vec = {read_enb_2, read_enb_1, read_enb_0};

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        router_fifo #(
            .DEPTH           (FIFO_DEPTH),
            .SOFT_RST_CYCLES (SOFT_RST_CYCLES)
        ) u_fifo (
            .clk      (clk),
            .resetn   (resetn),
            .wr_en    (wr_en_vec[g]),
            .wr_data  (fifo_wdata),
            .rd_en    (rd_en_vec[g]),
            .data_out (fifo_dout[g]),
            .vld_out  (fifo_vld[g]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g])
        );
    end

    assign data_out_0 = fifo_dout[0];
    assign data_out_1 = fifo_dout[1];
    assign data_out_2 = fifo_dout[2];
    assign vld_out_0  = fifo_vld[0];
    assign vld_out_1  = fifo_vld[1];
    assign vld_out_2  = fifo_vld[2];

endmodule

// File: tb/tb_router_modport.sv
// -----------------------------------------------------------------------------
// tb_router_modport -- scoreboard bench for router_modport.
// Stimulus pushes every byte it sends into the queue of its destination port.
// A separate monitor pops and compares on every pop the DUT performs.
// -----------------------------------------------------------------------------
module tb_router_modport;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    logic m_p0, m_p1, m_p2;

    router_modport dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .pkt_valid  (pkt_valid),
        .read_enb_0 (read_enb_0),
        .read_enb_1 (read_enb_1),
        .read_enb_2 (read_enb_2),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .vld_out_0  (vld_out_0),
        .vld_out_1  (vld_out_1),
        .vld_out_2  (vld_out_2),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] port, input logic [7:0] b);
        case (port)
            2'd0:    q0.push_back(b);
            2'd1:    q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic sb_pop(input int port, input logic [7:0] act);
        logic [7:0] exp;
        int         sz;
        case (port)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            n_checks++;
            $display("FAIL pop_port%0d: unexpected byte 0x%0h, expected no data", port, act);
        end else begin
            case (port)
                0:       exp = q0.pop_front();
                1:       exp = q1.pop_front();
                default: exp = q2.pop_front();
            endcase
            check($sformatf("pop_port%0d", port), 32'(act), 32'(exp));
        end
    endtask

    // Monitor: a pop happens at an edge where read_enb and vld_out were both
    // high; the popped byte is visible on data_out just after that edge.
    always @(posedge clk) begin
        m_p0 = read_enb_0 && vld_out_0;
        m_p1 = read_enb_1 && vld_out_1;
        m_p2 = read_enb_2 && vld_out_2;
        #1;
        if (m_p0) sb_pop(0, data_out_0);
        if (m_p1) sb_pop(1, data_out_1);
        if (m_p2) sb_pop(2, data_out_2);
    end

    // Present one byte and return on the negedge after an edge where busy was low.
    task automatic send_byte(input logic [7:0] d, input logic v);
        logic b;
        int   waits;
        data_in   = d;
        pkt_valid = v;
        waits     = 0;
        forever begin
            b = busy;
            @(posedge clk);
            @(negedge clk);
            if (!b) break;
            waits++;
            if (waits > 200) begin
                n_checks++;
                $display("FAIL send_timeout: busy still 1 after %0d cycles, expected 0", waits);
                break;
            end
        end
    endtask

    task automatic send_packet(input logic [1:0] addr, input int len,
                               input logic [7:0] base, input logic [7:0] par_xor);
        logic [5:0] l6;
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b;
        l6  = len[5:0];
        hdr = {l6, addr};
        par = hdr;
        push_exp(addr, hdr);
        send_byte(hdr, 1'b1);
        check("err_clear_on_header", 32'(err), 32'd0);
        for (int i = 0; i < len; i++) begin
            b   = base + 8'(i);
            par = par ^ b;
            push_exp(addr, b);
            send_byte(b, 1'b1);
        end
        par = par ^ par_xor;
        push_exp(addr, par);
        send_byte(par, 1'b0);
        data_in   = 8'h00;
        pkt_valid = 1'b0;
    endtask

    task automatic set_read(input int port, input logic v);
        case (port)
            0:       read_enb_0 = v;
            1:       read_enb_1 = v;
            default: read_enb_2 = v;
        endcase
    endtask

    function automatic int q_size(input int port);
        case (port)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Keep reading until the scoreboard queue for the port is empty.
    task automatic drain(input int port);
        int n;
        n = 0;
        set_read(port, 1'b1);
        while (q_size(port) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        set_read(port, 1'b0);
        check($sformatf("drain_port%0d_done", port), 32'(q_size(port)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int n;

        resetn     = 1'b0;
        data_in    = 8'h00;
        pkt_valid  = 1'b0;
        read_enb_0 = 1'b0;
        read_enb_1 = 1'b0;
        read_enb_2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_vld", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'd0);
        check("rst_dout0", 32'(data_out_0), 32'd0);
        check("rst_dout1", 32'(data_out_1), 32'd0);
        check("rst_dout2", 32'(data_out_2), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Good packet to port 1: 15 01 02 03 04 05, parity 0x14.
        send_packet(2'd1, 5, 8'h01, 8'h00);
        check("p1_vld_loaded", 32'(vld_out_1), 32'd1);
        @(negedge clk);
        check("good_err_checkstate", 32'(err), 32'd0);
        @(negedge clk);
        check("good_err_after", 32'(err), 32'd0);
        // Nine read cycles for seven bytes: the last two read an empty FIFO.
        set_read(1, 1'b1);
        repeat (9) @(negedge clk);
        set_read(1, 1'b0);
        check("p1_vld_drained", 32'(vld_out_1), 32'd0);
        check("p1_dout_hold", 32'(data_out_1), 32'h14);
        check("p1_queue_empty", 32'(q1.size()), 32'd0);

        // Corrupted parity 0x11 instead of 0x14.
        send_packet(2'd1, 5, 8'h01, 8'h05);
        @(negedge clk);
        check("bad_err_checkstate", 32'(err), 32'd0);
        @(negedge clk);
        check("bad_err_set", 32'(err), 32'd1);
        drain(1);
        check("bad_err_held", 32'(err), 32'd1);

        // Port 2, len 20: the FIFO fills and busy stays high until reads start.
        fork
            send_packet(2'd2, 20, 8'h20, 8'h00);
            begin
                hold = 0;
                n    = 0;
                while (hold < 5 && n < 100) begin
                    @(negedge clk);
                    n++;
                    hold = busy ? hold + 1 : 0;
                end
                check("full_busy_held", 32'(hold), 32'd5);
                check("full_vld2", 32'(vld_out_2), 32'd1);
                set_read(2, 1'b1);
            end
        join
        drain(2);
        repeat (4) @(negedge clk);
        check("full_vld2_drained", 32'(vld_out_2), 32'd0);
        check("full_err", 32'(err), 32'd0);

        // Second packet to a non-empty port 1 waits in WAIT_EMPTY.
        send_packet(2'd1, 2, 8'h40, 8'h00);
        fork
            send_packet(2'd1, 2, 8'h50, 8'h00);
            begin
                repeat (4) @(negedge clk);
                check("wait_empty_busy", 32'(busy), 32'd1);
                set_read(1, 1'b1);
            end
        join
        drain(1);
        repeat (4) @(negedge clk);
        check("wait_empty_vld1", 32'(vld_out_1), 32'd0);

        // Soft reset: port 0 loaded and never read is flushed.
        send_packet(2'd0, 2, 8'h60, 8'h00);
        n = 0;
        while (vld_out_0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("soft_flush_cycles", 32'(n), 32'd27);
        check("soft_vld0", 32'(vld_out_0), 32'd0);
        q0.delete();
        set_read(0, 1'b1);
        repeat (2) @(negedge clk);
        set_read(0, 1'b0);
        check("soft_dout0_untouched", 32'(data_out_0), 32'd0);

        // addr 3 header is dropped; a following port 0 packet routes normally.
        send_byte(8'h07, 1'b1);
        data_in   = 8'h00;
        pkt_valid = 1'b0;
        @(negedge clk);
        check("addr3_busy", 32'(busy), 32'd0);
        check("addr3_vld", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'd0);
        send_packet(2'd0, 3, 8'h70, 8'h00);
        drain(0);
        repeat (4) @(negedge clk);
        check("after_addr3_vld0", 32'(vld_out_0), 32'd0);

        // Reset in the middle of a packet leaves nothing behind.
        push_exp(2'd2, 8'h0E);
        send_byte(8'h0E, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        resetn    = 1'b1;
        data_in   = 8'h00;
        pkt_valid = 1'b0;
        q2.delete();
        @(negedge clk);
        check("midrst_vld2", 32'(vld_out_2), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);

        check("final_q0", 32'(q0.size()), 32'd0);
        check("final_q1", 32'(q1.size()), 32'd0);
        check("final_q2", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
